// File: rtl/scie_pkg.sv
// Shared constants for the custom FIR instruction unit: opcodes, default
// geometry and the accumulator width rule.
package scie_pkg;

  localparam int unsigned NTAPS = 5;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned FRAC  = 16;

  typedef enum logic [6:0] {
    OP_SETC = 7'h0B,
    OP_PUSH = 7'h2B,
    OP_READ = 7'h5B
  } opcode_e;

  // Full product width plus enough guard bits to sum ntaps signed products without overflow
  function automatic int unsigned acc_width(int unsigned ntaps, int unsigned xlen);
    return 2 * xlen + $clog2(ntaps) + 1;
  endfunction

  localparam int unsigned ACC_W = acc_width(NTAPS, XLEN);

endpackage

// File: rtl/scie_pipelined_fir_mac.sv
// Combinational multiply-add tree: full-width signed sum of coef[k]*x[k].
module fir_mac #(
  parameter int unsigned NTAPS = scie_pkg::NTAPS,
  parameter int unsigned XLEN  = scie_pkg::XLEN,
  parameter int unsigned SUM_W = scie_pkg::ACC_W
) (
  input  logic [NTAPS-1:0][XLEN-1:0] coef,
  input  logic [NTAPS-1:0][XLEN-1:0] x,
  output logic signed [SUM_W-1:0]    sum_c
);

  localparam int unsigned PW = 2 * XLEN;

  logic signed [PW-1:0] prod;

  // Operands are sign-extended to product width so the multiply is exact
  always_comb begin
    prod  = '0;
    sum_c = '0;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      prod  = PW'($signed(coef[k])) * PW'($signed(x[k]));
      sum_c = sum_c + SUM_W'(prod);
    end
  end

endmodule

// File: rtl/scie_pipelined.sv
// FIR instruction unit: decodes SETC/PUSH/READ, holds coefficients, sample
// history and the result register; the MAC tree is combinational.
module scie_pipelined #(
  parameter int unsigned NTAPS = scie_pkg::NTAPS,
  parameter int unsigned XLEN  = scie_pkg::XLEN,
  parameter int unsigned FRAC  = scie_pkg::FRAC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd
);

  import scie_pkg::*;

  localparam int unsigned SUM_W = acc_width(NTAPS, XLEN);

  logic [NTAPS-1:0][XLEN-1:0] coef;
  logic [NTAPS-1:0][XLEN-1:0] x;
  logic signed [SUM_W-1:0]    sum_c;
  logic [XLEN-1:0]            y;
  logic                       unused_bits;

  fir_mac #(
    .NTAPS(NTAPS),
    .XLEN (XLEN),
    .SUM_W(SUM_W)
  ) u_fir_mac (
    .coef (coef),
    .x    (x),
    .sum_c(sum_c)
  );

  // Truncating arithmetic shift: take the XLEN bits just above the fraction
  assign y = sum_c[XLEN+FRAC-1:FRAC];

  assign unused_bits = ^{io_insn[31:7], sum_c[SUM_W-1:XLEN+FRAC], sum_c[FRAC-1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      coef  <= '0;
      x     <= '0;
      io_rd <= '0;
    end else if (io_valid) begin
      case (io_insn[6:0])
        OP_SETC: begin
          // Out-of-range indices match no tap and are dropped
          for (int unsigned k = 0; k < NTAPS; k++) begin
            if (io_rs2 == XLEN'(k)) coef[k] <= io_rs1;
          end
        end
        OP_PUSH: begin
          x[0] <= io_rs1;
          for (int unsigned k = 1; k < NTAPS; k++) x[k] <= x[k-1];
        end
        OP_READ: io_rd <= y;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scie_pipelined.sv
// Self-checking bench for scie_pipelined: directed sequences with known
// results, then random instruction streams against a queue-based model.
module tb_scie_pipelined;

  localparam int unsigned NTAPS = 5;
  localparam logic [6:0] SETC = 7'h0B;
  localparam logic [6:0] PUSH = 7'h2B;
  localparam logic [6:0] READ = 7'h5B;

  logic        clock;
  logic        reset;
  logic        io_valid;
  logic [31:0] io_insn;
  logic [31:0] io_rs1;
  logic [31:0] io_rs2;
  logic [31:0] io_rd;

  int checks;
  int errors;

  // Reference state: coefficient table, newest-first sample history, result
  longint      m_coef [NTAPS];
  longint      m_hist [$];
  logic [31:0] m_rd;

  scie_pipelined dut (
    .clock   (clock),
    .reset   (reset),
    .io_valid(io_valid),
    .io_insn (io_insn),
    .io_rs1  (io_rs1),
    .io_rs2  (io_rs2),
    .io_rd   (io_rd)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < NTAPS; k++) m_coef[k] = 0;
    m_hist.delete();
    for (int k = 0; k < NTAPS; k++) m_hist.push_back(0);
    m_rd = '0;
  endfunction

  // Exact dot product in wide arithmetic, then floor-divide by 2^16
  function automatic logic [31:0] model_y();
    logic signed [127:0] acc;
    logic signed [127:0] q;
    acc = '0;
    for (int k = 0; k < NTAPS; k++) acc = acc + 128'(m_coef[k]) * 128'(m_hist[k]);
    q = acc >>> 16;
    return q[31:0];
  endfunction

  function automatic void model_step(input logic rst, input logic v, input logic [31:0] insn,
                                     input logic [31:0] rs1, input logic [31:0] rs2);
    if (rst) begin
      model_clear();
    end else if (v) begin
      if (insn[6:0] == SETC) begin
        if (rs2 < 32'(NTAPS)) m_coef[rs2] = longint'($signed(rs1));
      end else if (insn[6:0] == PUSH) begin
        m_hist.push_front(longint'($signed(rs1)));
        void'(m_hist.pop_back());
      end else if (insn[6:0] == READ) begin
        m_rd = model_y();
      end
    end
  endfunction

  // One clock: drive at the falling edge, update model at the rising edge, sample just after
  task automatic step(input logic rst, input logic v, input logic [31:0] insn,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    @(negedge clock);
    reset    = rst;
    io_valid = v;
    io_insn  = insn;
    io_rs1   = rs1;
    io_rs2   = rs2;
    @(posedge clock);
    model_step(rst, v, insn, rs1, rs2);
    #1;
    check("rd_vs_model", io_rd, m_rd);
  endtask

  task automatic op(input logic [6:0] opc, input logic [31:0] rs1, input logic [31:0] rs2);
    step(1'b0, 1'b1, {25'd0, opc}, rs1, rs2);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic load_coefs();
    int unsigned vals [NTAPS] = '{24736, 14753, 34125, 32773, 39926};
    for (int k = 0; k < NTAPS; k++) op(SETC, vals[k], 32'(k));
  endtask

  task automatic push_read(input logic [31:0] s, input logic [31:0] exp, input string tag);
    op(PUSH, s, 32'd0);
    idle();
    op(READ, 32'd0, 32'd0);
    check(tag, io_rd, exp);
  endtask

  initial begin
    int unsigned pick;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] hi;

    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    io_valid = 1'b0;
    io_insn  = '0;
    io_rs1   = '0;
    io_rs2   = '0;
    model_clear();

    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    step(1'b1, 1'b1, {25'd0, PUSH}, 32'd77, 32'd0);
    check("reset_rd", io_rd, 32'd0);

    load_coefs();
    push_read(32'd32965, 32'd12442, "first_read");
    push_read(32'd50287, 32'd26401, "push2");
    push_read(32'd7892,  32'd31464, "push3");
    push_read(32'd65167, 32'd69043, "push4_wide_sum");
    push_read(32'd60033, 32'd86668, "push5");

    op(SETC, 32'd1000, 32'd5);
    op(READ, 32'd0, 32'd0);
    check("setc_oob", io_rd, 32'd86668);

    step(1'b0, 1'b0, {25'd0, PUSH}, 32'd12345, 32'd0);
    check("hold_invalid_push", io_rd, 32'd86668);
    step(1'b0, 1'b0, {25'd0, SETC}, 32'd999, 32'd0);
    step(1'b0, 1'b1, 32'h0000_007B, 32'd4242, 32'd1);
    check("hold_unknown", io_rd, 32'd86668);
    op(READ, 32'd0, 32'd0);
    check("no_state_change", io_rd, 32'd86668);

    // Reading right after a PUSH with no gap must still see the new sample
    op(PUSH, 32'd1, 32'd0);
    op(READ, 32'd0, 32'd0);

    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    op(READ, 32'd0, 32'd0);
    check("read_after_reset", io_rd, 32'd0);
    load_coefs();
    push_read(32'd32965, 32'd12442, "reload_read");

    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    op(SETC, 32'hFFFF_0000, 32'd0);
    push_read(32'd5, 32'hFFFF_FFFB, "negative");

    // SETC after history is built affects later reads only
    op(SETC, 32'd65536, 32'd1);
    op(READ, 32'd0, 32'd0);
    op(PUSH, 32'd3, 32'd0);
    op(READ, 32'd0, 32'd0);
    check("setc_after_push", io_rd, 32'h0000_0002);

    for (int n = 0; n < 3000; n++) begin
      pick = $urandom_range(0, 99);
      rs1  = $urandom();
      if ($urandom_range(0, 3) == 0) rs1 = 32'($signed(16'($urandom())));
      rs2  = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) rs2 = $urandom();
      hi   = {$urandom(), 7'd0} & 32'hFFFF_FF80;
      if (pick < 2)       step(1'b1, 1'b1, hi | 32'(READ), rs1, rs2);
      else if (pick < 20) step(1'b0, 1'b1, hi | 32'(SETC), rs1, rs2);
      else if (pick < 45) step(1'b0, 1'b1, hi | 32'(PUSH), rs1, rs2);
      else if (pick < 70) step(1'b0, 1'b1, hi | 32'(READ), rs1, rs2);
      else if (pick < 80) step(1'b0, 1'b1, hi | 32'($urandom_range(0, 127)), rs1, rs2);
      else                step(1'b0, 1'b0, hi | 32'(PUSH), rs1, rs2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scie_pipelined.md
SCIE_PIPELINED -- requirements
Module: scie_pipelined

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: `clock` and `reset`.
REQ-002 Parameter NTAPS, default 5: number of FIR taps.
REQ-003 Parameter XLEN, default 32: operand and result width.
REQ-004 Parameter FRAC, default 16: fixed-point fraction bits dropped from the sum.
REQ-005 `clock`  in  1  rising-edge clock.
REQ-006 `reset`  in  1  synchronous active-high reset.
REQ-007 `io_valid`  in  1  instruction qualifier; all actions need io_valid=1 at the rising edge.
REQ-008 `io_insn`  in  32  instruction word; only bits [6:0] are decoded.
REQ-009 `io_rs1`  in  32  signed operand: coefficient value or sample value.
REQ-010 `io_rs2`  in  32  unsigned operand: coefficient index.
REQ-011 `io_rd`  out  32  signed result register.

Function
REQ-012 Opcode SETC = 7'h0B: at the edge, coef[io_rs2] <= io_rs1 if io_rs2 < NTAPS; otherwise no effect.
REQ-013 Opcode PUSH = 7'h2B: at the edge, x[k] <= x[k-1] for k = NTAPS-1 down to 1, and x[0] <= io_rs1.
REQ-014 Opcode READ = 7'h5B: at the edge, io_rd <= y.
REQ-015 y = (sum over k = 0..NTAPS-1 of coef[k]*x[k]) >> FRAC, using an arithmetic shift, bits [XLEN+FRAC-1 : FRAC] of the sum.
REQ-016 Arithmetic widths: signed XLEN x XLEN products (2*XLEN bits); accumulation in at least 2*XLEN+3 bits with no intermediate overflow; rounding by truncation only, after the full sum.
REQ-017 Latency: READ presented at edge k puts y on io_rd after edge k, for one cycle of latency.
  - That y reflects every SETC and PUSH committed at edges before k.
REQ-018 Pipelining is allowed, but a READ issued one idle cycle after the last PUSH SHALL return the fully updated result.
  - Pipeline stages must be invisible at the interface.
REQ-019 io_rd SHALL hold its value on every cycle without a valid READ.
REQ-020 A valid instruction with any other opcode, and any cycle with io_valid=0, SHALL change no state.
REQ-021 There is no back-pressure or busy output; one instruction may be accepted every cycle.
REQ-022 A SETC issued after PUSHes SHALL affect only subsequent READs; the sample history is kept.

Reset
REQ-023 While reset=1 at an edge, all coef[k], all x[k] and io_rd SHALL be cleared to 0, and instructions SHALL be ignored.
REQ-024 Reset applied mid-sequence SHALL discard all coefficients and history, so a following READ returns 0.

Structure
REQ-025 A shared package scie_pkg SHALL hold:
  - opcode constants SETC, PUSH, READ;
  - NTAPS, XLEN, FRAC;
  - the accumulator width constant.
REQ-026 One sub-module, fir_mac: combinational or registered multiply-add tree taking coef[] and x[] and producing the full-width sum.
  - Decode, coefficient registers, sample shift register and io_rd live in the top module.

Verification
REQ-027 Load and first read:
  - After reset, SETC with (rs1,rs2) = (24736,0), (14753,1), (34125,2), (32773,3), (39926,4).
  - Then PUSH 32965, one idle cycle, READ.
  - Required: io_rd = 12442 one cycle after READ.
REQ-028 Continue the sequence with PUSH, idle, READ for each sample:
  - PUSH 50287 -> io_rd = 26401;
  - PUSH 7892 -> io_rd = 31464;
  - PUSH 65167 -> io_rd = 69043, which checks that the sum is wider than 32 bits;
  - PUSH 60033 -> io_rd = 86668.
REQ-029 Out-of-range index: SETC with rs2=5, value 1000, followed by READ -> io_rd unchanged from the previous READ result, and no coefficient is modified.
REQ-030 Invalid and unknown instructions:
  - io_valid=0 with insn=PUSH/SETC -> no state change;
  - unknown opcode 7'h7B with valid -> no state change;
  - in both cases io_rd holds its value.
REQ-031 Reset mid-operation: reset pulse, then READ -> io_rd = 0; then reload coefficients and repeat REQ-027 -> io_rd = 12442.
REQ-032 Negative operands: coef[0] = -65536, others 0; PUSH 5, READ -> io_rd = -5, which checks signed products and the arithmetic shift.
